// File: rtl/sdram_cpu_bridge.sv
// 65C02 bus to SDRAM user-port bridge: synchronizes phi2, issues one 16-bit word request per selected CPU cycle, stalls via RDY.
// Optional one-entry read buffer enabled by defining SDRAM_BRIDGE_READ_CACHE_EN.
module sdram_cpu_bridge #(
  parameter int                        SDR_ADDR_WIDTH = 24,
  parameter logic [SDR_ADDR_WIDTH-1:0] BASE_WORD      = '0
) (
  input  logic                      i_sysclk,
  input  logic                      i_arst_n,
  input  logic                      i_cpu_phi2,
  input  logic                      i_cpu_sel,
  input  logic [15:0]               i_cpu_addr,
  input  logic                      i_cpu_rwb,
  input  logic [7:0]                i_cpu_data,
  output logic [7:0]                o_cpu_data,
  output logic                      o_cpu_rdy,
  output logic                      o_sdr_req,
  output logic                      o_sdr_we,
  output logic [SDR_ADDR_WIDTH-1:0] o_sdr_addr,
  output logic [15:0]               o_sdr_wdata,
  output logic [1:0]                o_sdr_be,
  input  logic                      i_sdr_ack,
  input  logic [15:0]               i_sdr_rdata,
  input  logic                      i_sdr_rvalid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

  state_t                    state;
  logic [2:0]                phi_sync;  // [0],[1] synchronizer, [2] edge-detect history
  logic                      phi_rise;
  logic                      phi_fall;
  logic                      byte_hi;
  logic                      read_hit;
  logic [SDR_ADDR_WIDTH-1:0] word_addr;

  assign phi_rise  = phi_sync[1] & ~phi_sync[2];
  assign phi_fall  = ~phi_sync[1] & phi_sync[2];
  assign word_addr = BASE_WORD + SDR_ADDR_WIDTH'(i_cpu_addr[15:1]);

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

`ifdef SDRAM_BRIDGE_READ_CACHE_EN
  logic                      cache_valid;
  logic [SDR_ADDR_WIDTH-1:0] cache_addr;
  logic [15:0]               cache_data;
  logic                      word_match;
  logic                      rd_complete;

  assign word_match  = cache_valid && (cache_addr == word_addr);
  assign read_hit    = word_match && i_cpu_rwb;
  assign rd_complete = ((state == REQ) && i_sdr_ack && i_sdr_rvalid && !o_sdr_we) ||
                       ((state == WAIT_RD) && i_sdr_rvalid);

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
    end else if (rd_complete) begin
      cache_valid <= 1'b1;
      cache_addr  <= o_sdr_addr;
      cache_data  <= i_sdr_rdata;
    end else if (state == IDLE && phi_rise && i_cpu_sel && !i_cpu_rwb && word_match) begin
      // Keep the buffer coherent with the byte the CPU is writing.
      if (i_cpu_addr[0]) cache_data[15:8] <= i_cpu_data;
      else               cache_data[7:0]  <= i_cpu_data;
    end
  end
`else
  assign read_hit = 1'b0;
`endif

  // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      phi_sync    <= '0;
      state       <= IDLE;
      byte_hi     <= 1'b0;
      o_cpu_data  <= 8'h00;
      o_cpu_rdy   <= 1'b1;
      o_sdr_req   <= 1'b0;
      o_sdr_we    <= 1'b0;
      o_sdr_addr  <= '0;
      o_sdr_wdata <= '0;
      o_sdr_be    <= '0;
    end else begin
      phi_sync <= {phi_sync[1:0], i_cpu_phi2};
      case (state)
        IDLE: begin
          if (phi_rise && i_cpu_sel) begin
            byte_hi <= i_cpu_addr[0];
            if (read_hit) begin
              o_cpu_data <= pick_byte(
`ifdef SDRAM_BRIDGE_READ_CACHE_EN
                                      cache_data,
`else
                                      16'h0000,
`endif
                                      i_cpu_addr[0]);
              state      <= DONE;
            end else begin
              o_cpu_rdy   <= 1'b0;
              o_sdr_req   <= 1'b1;
              o_sdr_we    <= ~i_cpu_rwb;
              o_sdr_addr  <= word_addr;
              o_sdr_wdata <= {i_cpu_data, i_cpu_data};
              o_sdr_be    <= {i_cpu_addr[0], ~i_cpu_addr[0]};
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (i_sdr_ack) begin
            o_sdr_req <= 1'b0;
            if (o_sdr_we) begin
              o_cpu_rdy <= 1'b1;
              state     <= DONE;
            end else if (i_sdr_rvalid) begin
              // Ack and data in the same cycle: finish the read now.
              o_cpu_data <= pick_byte(i_sdr_rdata, byte_hi);
              o_cpu_rdy  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (i_sdr_rvalid) begin
            o_cpu_data <= pick_byte(i_sdr_rdata, byte_hi);
            o_cpu_rdy  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          o_cpu_rdy <= 1'b1;
          if (phi_fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Directed bench for sdram_cpu_bridge with a read-data scoreboard; cache cases run when SDRAM_BRIDGE_READ_CACHE_EN is defined.
module tb_sdram_cpu_bridge;
  localparam int AW = 24;

  logic          sysclk = 1'b0;
  logic          arst_n = 1'b0;
  logic          cpu_phi2 = 1'b0;
  logic          cpu_sel = 1'b0;
  logic [15:0]   cpu_addr = '0;
  logic          cpu_rwb = 1'b1;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          cpu_rdy;
  logic          sdr_req;
  logic          sdr_we;
  logic [AW-1:0] sdr_addr;
  logic [15:0]   sdr_wdata;
  logic [1:0]    sdr_be;
  logic          sdr_ack = 1'b0;
  logic [15:0]   sdr_rdata = '0;
  logic          sdr_rvalid = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  sdram_cpu_bridge #(.SDR_ADDR_WIDTH(AW), .BASE_WORD('0)) dut (
    .i_sysclk(sysclk), .i_arst_n(arst_n), .i_cpu_phi2(cpu_phi2), .i_cpu_sel(cpu_sel),
    .i_cpu_addr(cpu_addr), .i_cpu_rwb(cpu_rwb), .i_cpu_data(cpu_wdata),
    .o_cpu_data(cpu_rdata), .o_cpu_rdy(cpu_rdy), .o_sdr_req(sdr_req), .o_sdr_we(sdr_we),
    .o_sdr_addr(sdr_addr), .o_sdr_wdata(sdr_wdata), .o_sdr_be(sdr_be),
    .i_sdr_ack(sdr_ack), .i_sdr_rdata(sdr_rdata), .i_sdr_rvalid(sdr_rvalid)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #500us;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full clock, leaving the bench on the falling edge for driving and sampling.
  task automatic cyc();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'd1, 32'd0);
    else check(tag, 32'(cpu_rdata), 32'(exp_q.pop_front()));
  endtask

  // Raw phi2 rise, then the three edges up to the registered response.
  task automatic start_rise(input logic [15:0] addr, input logic rwb, input logic [7:0] data,
                            input logic sel);
    cpu_addr  = addr;
    cpu_rwb   = rwb;
    cpu_wdata = data;
    cpu_sel   = sel;
    cpu_phi2  = 1'b1;
    cyc();
    cyc();
    check("rdy_before_third_edge", 32'(cpu_rdy), 32'd1);
    cyc();
  endtask

  task automatic end_cycle();
    cpu_phi2 = 1'b0;
    cpu_sel  = 1'b0;
    repeat (4) cyc();
    check("idle_rdy", 32'(cpu_rdy), 32'd1);
  endtask

  task automatic check_req(input string tag, input logic [15:0] addr, input logic we);
    check({tag, "_rdy_low"}, 32'(cpu_rdy), 32'd0);
    check({tag, "_req"}, 32'(sdr_req), 32'd1);
    check({tag, "_we"}, 32'(sdr_we), 32'(we));
    check({tag, "_addr"}, 32'(sdr_addr), 32'(addr >> 1));
    check({tag, "_be"}, 32'(sdr_be), addr[0] ? 32'd2 : 32'd1);
  endtask

  task automatic hold_until_ack(input string tag, input int dly, input logic [15:0] addr);
    int bad = 0;
    for (int i = 0; i < dly; i++) begin
      cyc();
      if (!sdr_req || cpu_rdy || sdr_addr !== AW'(addr >> 1)) bad++;
    end
    check({tag, "_held_until_ack"}, 32'(bad), 32'd0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int ack_dly);
    start_rise(addr, 1'b0, data, 1'b1);
    check_req("wr", addr, 1'b1);
    check("wr_wdata", 32'(sdr_wdata), 32'({data, data}));
    hold_until_ack("wr", ack_dly, addr);
    sdr_ack = 1'b1;
    cyc();
    sdr_ack = 1'b0;
    check("wr_rdy_after_ack", 32'(cpu_rdy), 32'd1);
    check("wr_req_dropped", 32'(sdr_req), 32'd0);
    end_cycle();
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] word, input int ack_dly,
                         input int rv_dly, input logic same_cycle);
    exp_q.push_back(addr[0] ? word[15:8] : word[7:0]);
    start_rise(addr, 1'b1, 8'h00, 1'b1);
    check_req("rd", addr, 1'b0);
    hold_until_ack("rd", ack_dly, addr);
    sdr_ack = 1'b1;
    if (same_cycle) begin
      sdr_rvalid = 1'b1;
      sdr_rdata  = word;
    end
    cyc();
    sdr_ack    = 1'b0;
    sdr_rvalid = 1'b0;
    if (!same_cycle) begin
      check("rd_wait_rdy_low", 32'(cpu_rdy), 32'd0);
      check("rd_wait_req_dropped", 32'(sdr_req), 32'd0);
      repeat (rv_dly) cyc();
      check("rd_rdy_low_before_rvalid", 32'(cpu_rdy), 32'd0);
      sdr_rvalid = 1'b1;
      sdr_rdata  = word;
      cyc();
      sdr_rvalid = 1'b0;
    end
    check("rd_rdy_after_rvalid", 32'(cpu_rdy), 32'd1);
    pop_check("rd_data");
    end_cycle();
  endtask

`ifdef SDRAM_BRIDGE_READ_CACHE_EN
  task automatic do_hit_read(input logic [15:0] addr, input logic [7:0] exp_byte);
    exp_q.push_back(exp_byte);
    start_rise(addr, 1'b1, 8'h00, 1'b1);
    check("hit_no_req", 32'(sdr_req), 32'd0);
    check("hit_rdy", 32'(cpu_rdy), 32'd1);
    pop_check("hit_data");
    end_cycle();
  endtask
`endif

  initial begin
    int seen;
    // Reset state
    repeat (3) cyc();
    check("rst_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_cpu_data", 32'(cpu_rdata), 32'd0);
    check("rst_req", 32'(sdr_req), 32'd0);
    check("rst_we", 32'(sdr_we), 32'd0);
    check("rst_addr", 32'(sdr_addr), 32'd0);
    check("rst_wdata", 32'(sdr_wdata), 32'd0);
    check("rst_be", 32'(sdr_be), 32'd0);
    arst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (sdr_req || !cpu_rdy) seen++;
    end
    check("idle_100_cycles", 32'(seen), 32'd0);

    // Write 0x1235 <= 0xA5: word 0x091A, upper lane
    do_write(16'h1235, 8'hA5, 4);
    check("wr_addr_const", 32'(sdr_addr), 32'h091A);

    do_read(16'h1234, 16'hBEEF, 2, 3, 1'b0);
`ifdef SDRAM_BRIDGE_READ_CACHE_EN
    do_hit_read(16'h1235, 8'hBE);
`else
    do_read(16'h1235, 16'hBEEF, 1, 1, 1'b0);
`endif
    check("rd_upper_const", 32'(cpu_rdata), 32'hBE);

    // Ack and rvalid together
    do_read(16'h0101, 16'h5A3C, 0, 0, 1'b1);

    // Unselected rise
    cpu_sel  = 1'b0;
    cpu_phi2 = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (sdr_req || !cpu_rdy) seen++;
    end
    check("unsel_no_request", 32'(seen), 32'd0);
    cpu_phi2 = 1'b0;
    repeat (3) cyc();

    // Spurious rvalid in IDLE
    sdr_rvalid = 1'b1;
    sdr_rdata  = 16'hFFFF;
    cyc();
    sdr_rvalid = 1'b0;
    cyc();
    check("spurious_rvalid_data", 32'(cpu_rdata), 32'h5A);

    // Reset while waiting for read data
    start_rise(16'h4000, 1'b1, 8'h00, 1'b1);
    sdr_ack = 1'b1;
    cyc();
    sdr_ack = 1'b0;
    check("midrd_wait_rdy", 32'(cpu_rdy), 32'd0);
    arst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(cpu_rdy), 32'd1);
    check("midrst_req", 32'(sdr_req), 32'd0);
    check("midrst_data", 32'(cpu_rdata), 32'd0);
    check("midrst_addr", 32'(sdr_addr), 32'd0);
    cpu_phi2 = 1'b0;
    cpu_sel  = 1'b0;
    cyc();
    cyc();
    arst_n = 1'b1;
    cyc();
    sdr_rvalid = 1'b1;
    sdr_rdata  = 16'hDEAD;
    cyc();
    sdr_rvalid = 1'b0;
    cyc();
    check("late_rvalid_data", 32'(cpu_rdata), 32'd0);
    check("late_rvalid_rdy", 32'(cpu_rdy), 32'd1);
    do_read(16'h4000, 16'h7788, 1, 2, 1'b0);

`ifdef SDRAM_BRIDGE_READ_CACHE_EN
    do_read(16'h2000, 16'h1122, 1, 1, 1'b0);
    do_hit_read(16'h2001, 8'h11);
    do_write(16'h2000, 8'h33, 1);
    do_hit_read(16'h2000, 8'h33);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_cpu_bridge.md
# sdram_cpu_bridge

Bridges the 65C02 bus to the native request port of the SDRAM controller inside `super6502`, on the `i_sysclk` (100 MHz) domain. It detects a selected CPU cycle on `cpu_phi2` and translates the 8-bit access into a 16-bit SDRAM word request with byte enables. It stalls the CPU through `cpu_rdy` until the write is accepted or the read data returns. Upstream is the CPU address decode; downstream is the SDRAM controller user port.

## Interface
Parameters:
- `SDR_ADDR_WIDTH`, 24: SDRAM word-address width on `o_sdr_addr`.
- `BASE_WORD`, 0: SDRAM word offset added to the CPU word address.

Ports:
- `i_sysclk`  in  1  system clock; the single clock, all logic on its rising edge.
- `i_arst_n`  in  1  reset, asynchronous, active-low.
- `i_cpu_phi2`  in  1  CPU phase-2 clock, asynchronous; sampled as data.
- `i_cpu_sel`  in  1  decode: current address targets SDRAM.
- `i_cpu_addr`  in  16  CPU address.
- `i_cpu_rwb`  in  1  1 = read, 0 = write.
- `i_cpu_data`  in  8  CPU write data.
- `o_cpu_data`  out  8  read data to CPU.
- `o_cpu_rdy`  out  1  0 = stall CPU.
- `o_sdr_req`  out  1  request valid.
- `o_sdr_we`  out  1  1 = write request.
- `o_sdr_addr`  out  SDR_ADDR_WIDTH  word address = BASE_WORD + {0, i_cpu_addr[15:1]}.
- `o_sdr_wdata`  out  16  write data, CPU byte replicated on both lanes.
- `o_sdr_be`  out  2  byte enable; bit 0 = addr[0]==0, bit 1 = addr[0]==1.
- `i_sdr_ack`  in  1  request accepted this cycle.
- `i_sdr_rdata`  in  16  read data.
- `i_sdr_rvalid`  in  1  read data valid, one cycle.

## Operation
- `i_cpu_phi2` passes through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized copy.
- States: IDLE, REQ, WAIT_RD, DONE.
- IDLE: on a sync rise with `i_cpu_sel`=1, latch addr, rwb and data, drive `o_cpu_rdy`=0, assert `o_sdr_req` and go to REQ. A sync rise with sel=0 is ignored.
- REQ: hold req, we, addr, wdata and be stable until `i_sdr_ack`=1. On ack, drop req. A write goes to DONE. A read goes to WAIT_RD.
- WAIT_RD: on `i_sdr_rvalid`, register byte `rdata[7:0]` if addr[0]=0, else `rdata[15:8]`, into `o_cpu_data`. Set `o_cpu_rdy`=1 and go to DONE.
- DONE: `o_cpu_rdy`=1. On a sync fall of phi2, return to IDLE.
- `i_sdr_rvalid` outside WAIT_RD is ignored. `o_cpu_data` holds its last value.
- Address arithmetic wraps modulo 2^SDR_ADDR_WIDTH.

## Timing
- Reset values: `o_cpu_rdy`=1, `o_cpu_data`=0x00, `o_sdr_req`=0, `o_sdr_we`=0, `o_sdr_addr`=0, `o_sdr_wdata`=0, `o_sdr_be`=0. Synchronizer flops = 0. State = IDLE.
- Raw phi2 rise to `o_cpu_rdy`=0 and `o_sdr_req`=1: 3 `i_sysclk` edges (2 sync, 1 register).
- `o_sdr_req` may drop no earlier than the edge after the ack cycle.
- Write: `o_cpu_rdy`=1 on the edge after the ack cycle.
- Read: `o_cpu_data` and `o_cpu_rdy`=1 update on the same edge following the rvalid cycle.
- An ack and rvalid arriving in the same cycle are both honoured: REQ goes to DONE with data captured.
- A phi2 fall seen while in REQ or WAIT_RD is ignored; the CPU is held by RDY. A new rise is accepted only from IDLE.
- Reset mid-transaction: all outputs return to reset values immediately. Any outstanding controller transaction is abandoned, and its later ack or rvalid is ignored.

## Configuration
- `SDRAM_BRIDGE_READ_CACHE_EN`: when defined, adds a one-entry read buffer holding a valid bit, the word address and 16 bits of data.
  - A read whose word address matches the valid entry skips REQ and WAIT_RD. The selected byte and `o_cpu_rdy`=1 are set on the edge after detection, with no `o_sdr_req`.
  - Every completed SDRAM read fills the entry.
  - A write to the cached word updates the enabled byte in the buffer.
  - Reset clears the valid bit.
- When not defined, every read goes to SDRAM and no buffer logic exists.

## Test plan
- Reset held low, then released with phi2 idle: all outputs are at reset values and `o_sdr_req` stays 0 for 100 cycles.
- Write to addr 0x1235, data 0xA5, ack after 4 cycles: `o_sdr_addr`=0x091A, `o_sdr_be`=2'b10, `o_sdr_wdata`=0xA5A5. RDY goes low 3 edges after the rise and returns high the edge after the ack.
- Read from addr 0x1234 with rvalid data 0xBEEF: `o_cpu_data`=0xEF. Read from 0x1235: 0xBE. RDY stays low until the edge after rvalid.
- Phi2 rise with `i_cpu_sel`=0: no request is issued and RDY stays 1. A spurious `i_sdr_rvalid` in IDLE leaves `o_cpu_data` unchanged.
- Reset asserted in WAIT_RD, then rvalid arrives: outputs are reset and the data is ignored. The next selected read completes normally.
- With `SDRAM_BRIDGE_READ_CACHE_EN`: read 0x2000 (SDRAM returns 0x1122), then read 0x2001. The second read completes with data 0x11 and no `o_sdr_req`. A write of 0x33 to 0x2000 followed by a read of 0x2000 returns 0x33.
